// File: rtl/keypad_emulator.sv
// keypad_emulator: keypad-side responder for a 4x4 active-low scanned switch matrix, fed from a key-code queue.
// Optional contact bounce at the start of each press: define KEYPAD_EMU_BOUNCE_EN.

// Generic synchronous FIFO with an occupancy count.
// Latency: a pushed word is poppable the cycle after the push edge.
// Backpressure: push_rdy drops while full; pops are honoured only when pop_vld.
module keypad_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                           CLOCK_50,
   input  logic                           Reset,
   input  logic                           push_vld,
   output logic                           push_rdy,
   input  logic [WIDTH-1:0]               push_dat,
   output logic                           pop_vld,
   input  logic                           pop_rdy,
   output logic [WIDTH-1:0]               pop_dat,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push_fire;
   logic             pop_fire;

   assign push_rdy  = (count != CW'(DEPTH));
   assign pop_vld   = (count != '0);
   assign push_fire = push_vld && push_rdy;
   assign pop_fire  = pop_rdy && pop_vld;
   assign pop_dat   = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap on their own
   always_ff @(posedge CLOCK_50) begin
      if (!Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_fire) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_fire, pop_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// Keypad emulator: pops key codes and holds each closed, then open, for fixed times.
// Latency: contact closes one cycle after a code is accepted into an empty queue; cols_n->rows_n is combinational.
// Backpressure: key_ready drops while the queue holds FIFO_DEPTH codes.
module keypad_emulator #(
   parameter int PRESS_CYCLES  = 200000,
   parameter int GAP_CYCLES    = 200000,
   parameter int FIFO_DEPTH    = 4,
   parameter int BOUNCE_CYCLES = 2000,
   parameter int BOUNCE_PERIOD = 250
) (
   input  logic                                CLOCK_50,
   input  logic                                Reset,
   input  logic [3:0]                          key_code,
   input  logic                                key_valid,
   output logic                                key_ready,
   input  logic [3:0]                          cols_n,
   output logic [3:0]                          rows_n,
   output logic                                pressed,
   output logic [3:0]                          cur_key,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
   output logic                                busy
);
   localparam int MAX_CYC = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

   if (PRESS_CYCLES < 1 || GAP_CYCLES < 1 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       BOUNCE_PERIOD < 1 || BOUNCE_CYCLES >= PRESS_CYCLES) begin : g_bad_cfg
      $error("keypad_emulator: illegal parameter combination");
   end

   typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

   typedef struct packed {
      logic [1:0] row;
      logic [1:0] col;
   } key_pos_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             contact, contact_nxt;
   logic [3:0]       cur_key_nxt;
   logic             start_press;
   logic             pop_vld;
   logic             pop_rdy;
   logic [3:0]       pop_dat;
   key_pos_t         key_pos;

`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam int PCNT_W = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
   localparam logic [PCNT_W-1:0] PCNT_LOAD   = PCNT_W'(BOUNCE_PERIOD - 1);
   localparam logic [CNT_W:0]    BOUNCE_EDGE = (CNT_W + 1)'(PRESS_CYCLES - BOUNCE_CYCLES);

   logic [PCNT_W-1:0] pcnt, pcnt_nxt;
`endif

   keypad_fifo #(
      .WIDTH (4),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLOCK_50 (CLOCK_50),
      .Reset    (Reset),
      .push_vld (key_valid),
      .push_rdy (key_ready),
      .push_dat (key_code),
      .pop_vld  (pop_vld),
      .pop_rdy  (pop_rdy),
      .pop_dat  (pop_dat),
      .count    (fifo_count)
   );

   assign pop_rdy = start_press;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      contact_nxt = contact;
      cur_key_nxt = cur_key;
      start_press = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      pcnt_nxt    = pcnt;
`endif
      unique case (state)
         IDLE: begin
            start_press = pop_vld;
         end
         PRESS: begin
            if (cnt == '0) begin
               contact_nxt = 1'b0;
               cnt_nxt     = GAP_LOAD;
               state_nxt   = GAP;
            end else begin
               cnt_nxt = cnt - 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
               // cnt above the edge means the next press cycle is still inside the bounce window
               if ({1'b0, cnt} > BOUNCE_EDGE) begin
                  if (pcnt == '0) begin
                     contact_nxt = ~contact;
                     pcnt_nxt    = PCNT_LOAD;
                  end else begin
                     pcnt_nxt = pcnt - 1'b1;
                  end
               end else begin
                  contact_nxt = 1'b1;
               end
`endif
            end
         end
         GAP: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else if (pop_vld) begin
               start_press = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (start_press) begin
         state_nxt   = PRESS;
         cnt_nxt     = PRESS_LOAD;
         contact_nxt = 1'b1;
         cur_key_nxt = pop_dat;
`ifdef KEYPAD_EMU_BOUNCE_EN
         pcnt_nxt    = PCNT_LOAD;
`endif
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!Reset) begin
         state   <= IDLE;
         cnt     <= '0;
         contact <= 1'b0;
         cur_key <= 4'h0;
`ifdef KEYPAD_EMU_BOUNCE_EN
         pcnt    <= '0;
`endif
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         contact <= contact_nxt;
         cur_key <= cur_key_nxt;
`ifdef KEYPAD_EMU_BOUNCE_EN
         pcnt    <= pcnt_nxt;
`endif
      end
   end

   // Switch position of each code: rows 1-2-3-A / 4-5-6-B / 7-8-9-C / E-0-F-D
   always_comb begin
      key_pos = '{row: 2'd0, col: 2'd0};
      case (cur_key)
         4'h1: key_pos = '{row: 2'd0, col: 2'd0};
         4'h2: key_pos = '{row: 2'd0, col: 2'd1};
         4'h3: key_pos = '{row: 2'd0, col: 2'd2};
         4'hA: key_pos = '{row: 2'd0, col: 2'd3};
         4'h4: key_pos = '{row: 2'd1, col: 2'd0};
         4'h5: key_pos = '{row: 2'd1, col: 2'd1};
         4'h6: key_pos = '{row: 2'd1, col: 2'd2};
         4'hB: key_pos = '{row: 2'd1, col: 2'd3};
         4'h7: key_pos = '{row: 2'd2, col: 2'd0};
         4'h8: key_pos = '{row: 2'd2, col: 2'd1};
         4'h9: key_pos = '{row: 2'd2, col: 2'd2};
         4'hC: key_pos = '{row: 2'd2, col: 2'd3};
         4'hE: key_pos = '{row: 2'd3, col: 2'd0};
         4'h0: key_pos = '{row: 2'd3, col: 2'd1};
         4'hF: key_pos = '{row: 2'd3, col: 2'd2};
         4'hD: key_pos = '{row: 2'd3, col: 2'd3};
         default: key_pos = '{row: 2'd0, col: 2'd0};
      endcase
   end

   // Bit 3 is index 0 on both buses, hence the inverted indices; reset forces the matrix open at once
   always_comb begin
      rows_n = 4'hF;
      if (Reset && contact && !cols_n[~key_pos.col]) begin
         rows_n[~key_pos.row] = 1'b0;
      end
   end

   assign pressed = (state == PRESS);
   assign busy    = (state != IDLE) || (fifo_count != '0);
endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: scoreboard of accepted codes checked at each stroke start.
module tb_keypad_emulator;
`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam int PRESS = 40;
   localparam int BC    = 12;
   localparam int BP    = 3;
`else
   localparam int PRESS = 8;
   localparam int BC    = 2;
   localparam int BP    = 1;
`endif
   localparam int GAP    = 4;
   localparam int DEPTH  = 4;
   localparam int PERIOD = PRESS + GAP;

   localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                          4'h4, 4'h5, 4'h6, 4'hB,
                                          4'h7, 4'h8, 4'h9, 4'hC,
                                          4'hE, 4'h0, 4'hF, 4'hD};

   logic                         CLOCK_50;
   logic                         Reset;
   logic [3:0]                   key_code;
   logic                         key_valid;
   logic                         key_ready;
   logic [3:0]                   cols_n;
   logic [3:0]                   rows_n;
   logic                         pressed;
   logic [3:0]                   cur_key;
   logic [$clog2(DEPTH+1)-1:0]   fifo_count;
   logic                         busy;

   int         vectors;
   int         miscompares;
   int         cyc;
   int         last_start;
   int         t0;
   bit         b2b;
   logic       prev_pressed;
   logic [3:0] exp_q [$];

   keypad_emulator #(
      .PRESS_CYCLES  (PRESS),
      .GAP_CYCLES    (GAP),
      .FIFO_DEPTH    (DEPTH),
      .BOUNCE_CYCLES (BC),
      .BOUNCE_PERIOD (BP)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .Reset      (Reset),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .cols_n     (cols_n),
      .rows_n     (rows_n),
      .pressed    (pressed),
      .cur_key    (cur_key),
      .fifo_count (fifo_count),
      .busy       (busy)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, miscompares so far %0d", miscompares);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Contact state expected k cycles into a press
   function automatic logic exp_contact(input int k);
`ifdef KEYPAD_EMU_BOUNCE_EN
      return (k < BC) ? (((k / BP) % 2) == 0) : 1'b1;
`else
      return (k >= 0);
`endif
   endfunction

   function automatic logic [3:0] exp_rows(input logic [3:0] code, input logic [3:0] cols, input logic con);
      logic [3:0] r;
      logic [1:0] rr;
      logic [1:0] cc;
      r = 4'hF;
      for (int i = 0; i < 16; i++) begin
         rr = 2'(i / 4);
         cc = 2'(i % 4);
         if (KEYMAP[i] == code && con && !cols[2'd3 - cc]) r[2'd3 - rr] = 1'b0;
      end
      return r;
   endfunction

   // One clock: records accepted codes, and at each stroke start checks the popped code and period
   task automatic tick();
      logic       acc;
      logic       rst_in;
      logic [3:0] code_in;
      logic [3:0] code;
      acc     = key_valid && key_ready && Reset;
      rst_in  = Reset;
      code_in = key_code;
      @(posedge CLOCK_50);
      #1;
      cyc++;
      if (!rst_in) exp_q.delete();
      if (acc) exp_q.push_back(code_in);
      if (pressed === 1'b1 && prev_pressed !== 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'(exp_q.size()), 1);
         end else begin
            code = exp_q.pop_front();
            chk("sb_cur_key", cur_key, code);
            if (b2b && last_start >= 0) chk("stroke_period", cyc - last_start, PERIOD);
            last_start = cyc;
         end
      end
      prev_pressed = pressed;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget && busy !== 1'b0; i++) tick();
      chk(tag, busy, 1'b0);
   endtask

   initial begin
      vectors = 0; miscompares = 0; cyc = 0; last_start = -1; t0 = 0; b2b = 0;
      prev_pressed = 1'b0;
      Reset = 1'b0; key_valid = 1'b0; key_code = 4'h0; cols_n = 4'hF;

      // Reset state, with a full sweep of the column strobes
      tick(); tick();
      for (int i = 0; i < 16; i++) begin
         cols_n = 4'(i);
         #1;
         chk("t1_rows_in_reset", rows_n, 4'hF);
      end
      chk("t1_key_ready", key_ready, 1'b1);
      chk("t1_fifo_count", fifo_count, 0);
      chk("t1_busy", busy, 1'b0);
      chk("t1_pressed", pressed, 1'b0);
      chk("t1_cur_key", cur_key, 4'h0);
      Reset = 1'b1;
      cols_n = 4'b1011;
      tick();
      chk("t1_idle_busy", busy, 1'b0);

      // Single stroke of key 5 on column 1
      key_code = 4'h5; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      chk("t2_rows_at_accept", rows_n, 4'hF);
      chk("t2_count_at_accept", fifo_count, 1);
      chk("t2_busy_at_accept", busy, 1'b1);
      for (int k = 0; k < PRESS; k++) begin
         tick();
         chk("t2_pressed", pressed, 1'b1);
         chk("t2_rows", rows_n, exp_rows(4'h5, cols_n, exp_contact(k)));
         if (k == PRESS - 2) begin
            chk("t2_rows_closed", rows_n, 4'b1011);
            cols_n = 4'b0111;
            #1;
            chk("t2_rows_other_col", rows_n, 4'hF);
            cols_n = 4'b1011;
            #1;
         end
      end
      tick();
      chk("t2_released", pressed, 1'b0);
      chk("t2_rows_gap", rows_n, 4'hF);
      for (int k = 0; k < GAP - 1; k++) tick();
      chk("t2_busy_end_gap", busy, 1'b1);
      tick();
      chk("t2_idle", busy, 1'b0);

      // Corner keys E and A, plus multiple-column strobes
      cols_n = 4'b0111; key_code = 4'hE; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      tick();
      chk("t3_rows_E", rows_n, 4'b1110);
      wait_idle("t3_idle_E", PERIOD + 4);
      cols_n = 4'b1110; key_code = 4'hA; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      tick();
      chk("t3_rows_A", rows_n, 4'b0111);
      cols_n = 4'b0000;
      #1;
      chk("t3_rows_A_all_cols", rows_n, 4'b0111);
      cols_n = 4'b1101;
      #1;
      chk("t3_rows_A_wrong_col", rows_n, 4'hF);
      wait_idle("t3_idle_A", PERIOD + 4);

      // Held key_valid with codes 1..6: queue fills, 6 waits for the first pop after stroke 1
      cols_n = 4'hF; b2b = 1'b1; last_start = -1; key_valid = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         key_code = 4'(i);
         chk("t4_ready", key_ready, 1'b1);
         tick();
         if (i == 1) t0 = cyc;
      end
      chk("t4_full_ready", key_ready, 1'b0);
      chk("t4_full_count", fifo_count, DEPTH);
      key_code = 4'h6;
      for (int i = 0; i < 3 * PERIOD && key_ready !== 1'b1; i++) tick();
      chk("t4_ready_again", key_ready, 1'b1);
      tick();
      key_valid = 1'b0;
      chk("t4_accept6_cycle", cyc - t0, PERIOD + 2);
      wait_idle("t4_idle", 7 * PERIOD);
      chk("t4_sb_drained", 32'(exp_q.size()), 0);
      b2b = 1'b0;

      // Reset three cycles into a press with two codes queued
      cols_n = 4'b0111; key_valid = 1'b1;
      key_code = 4'h7; tick();
      key_code = 4'h8; tick();
      key_code = 4'h9; tick();
      key_valid = 1'b0;
      tick(); tick();
      chk("t5_pressed", pressed, 1'b1);
      chk("t5_count", fifo_count, 2);
      chk("t5_rows", rows_n, exp_rows(4'h7, cols_n, exp_contact(3)));
      Reset = 1'b0;
      tick();
      chk("t5_rows_reset", rows_n, 4'hF);
      chk("t5_count_reset", fifo_count, 0);
      chk("t5_pressed_reset", pressed, 1'b0);
      chk("t5_busy_reset", busy, 1'b0);
      chk("t5_cur_key_reset", cur_key, 4'h0);
      chk("t5_ready_reset", key_ready, 1'b1);
      Reset = 1'b1;
      tick(); tick(); tick();
      chk("t5_stays_idle", busy, 1'b0);
      chk("t5_no_press", pressed, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
